// File: rtl/circular_deconvolution.sv
// ============================================================================
// circular_deconvolution: recovers A from Y = A (*) B by recursive division.
// Optional tail-residual check enabled by DECONV_RESIDUAL_CHECK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module circular_deconvolution #(
   parameter int SIZE_N = 4,
   parameter int SIZE_M = 4,
   parameter int WIDTH  = 8
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   start,
   input  logic [SIZE_M-1:0][WIDTH-1:0]           B,
   input  logic [SIZE_N+SIZE_M-2:0][2*WIDTH-1:0]  Y,
   output logic [SIZE_N-1:0][2*WIDTH-1:0]         A,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   div_zero,
   output logic                                   inexact,
   output logic                                   ovf,
   output logic                                   mismatch
);

   localparam int c_AW = 3*WIDTH + $clog2(SIZE_M) + 1;
   localparam int c_PW = 3*WIDTH;
   localparam int c_YN = SIZE_N + SIZE_M - 1;
   localparam int c_IW = $clog2(c_YN + 1);

   localparam logic [c_IW-1:0] c_MLAST = c_IW'(SIZE_M - 1);
   localparam logic [c_IW-1:0] c_NLAST = c_IW'(SIZE_N - 1);
   localparam logic signed [c_AW-1:0] c_QMAX = c_AW'((2**(2*WIDTH-1)) - 1);
   localparam logic signed [c_AW-1:0] c_QMIN = -c_QMAX - c_AW'(1);

`ifdef DECONV_RESIDUAL_CHECK_EN
   localparam logic [c_IW-1:0] c_YLAST = c_IW'(c_YN - 1);
   typedef enum logic [2:0] {
      IDLE = 3'd0, INIT = 3'd1, MAC = 3'd2, DIV = 3'd3,
      CHK_INIT = 3'd4, CHK_MAC = 3'd5, CHK_CMP = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE = 3'd0, INIT = 3'd1, MAC = 3'd2, DIV = 3'd3
   } state_t;
`endif

   state_t r_state, w_state_nxt;

   logic [SIZE_M-1:0][WIDTH-1:0]     r_b;
   logic [c_YN-1:0][2*WIDTH-1:0]     r_y;
   logic [SIZE_N-1:0][2*WIDTH-1:0]   r_a;
   logic signed [c_AW-1:0]           r_acc;
   logic [c_IW-1:0]                  r_k, r_i;
   logic                             r_busy, r_done, r_div_zero, r_inexact, r_ovf;

   logic signed [WIDTH-1:0]          w_bsel;
   logic signed [2*WIDTH-1:0]        w_asel, w_ysel, w_qsat;
   logic [c_IW-1:0]                  w_j, w_lim;
   logic signed [c_PW-1:0]           w_prod;
   logic signed [c_AW-1:0]           w_mac, w_b0, w_quo, w_rem;
   logic                             w_sat_hi, w_sat_lo;

   // Variable-index selects written as compare loops so index widths stay exact
   always_comb begin
      w_j    = r_k - r_i;
      w_bsel = '0;
      w_asel = '0;
      w_ysel = '0;
      for (int j = 0; j < SIZE_M; j++)
         if (r_i == c_IW'(j)) w_bsel = r_b[j];
      for (int j = 0; j < SIZE_N; j++)
         if (w_j == c_IW'(j)) w_asel = r_a[j];
      for (int j = 0; j < c_YN; j++)
         if (r_k == c_IW'(j)) w_ysel = r_y[j];
   end

   assign w_prod   = c_PW'(w_bsel) * c_PW'(w_asel);
   assign w_mac    = r_acc - c_AW'(w_prod);
   assign w_lim    = (r_k < c_MLAST) ? r_k : c_MLAST;
   assign w_b0     = c_AW'($signed(r_b[0]));
   assign w_quo    = r_acc / w_b0;
   assign w_rem    = r_acc % w_b0;
   assign w_sat_hi = (w_quo > c_QMAX);
   assign w_sat_lo = (w_quo < c_QMIN);
   assign w_qsat   = w_sat_hi ? c_QMAX[2*WIDTH-1:0] :
                     w_sat_lo ? c_QMIN[2*WIDTH-1:0] : w_quo[2*WIDTH-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (start && (B[0] != '0)) w_state_nxt = INIT;
         INIT:     w_state_nxt = (r_k == '0) ? DIV : MAC;
         MAC:      if (r_i == w_lim) w_state_nxt = DIV;
`ifdef DECONV_RESIDUAL_CHECK_EN
         DIV:      w_state_nxt = (r_k == c_NLAST) ? CHK_INIT : INIT;
         CHK_INIT: w_state_nxt = CHK_MAC;
         CHK_MAC:  if (r_i == c_MLAST) w_state_nxt = CHK_CMP;
         CHK_CMP:  w_state_nxt = (r_k == c_YLAST) ? IDLE : CHK_INIT;
`else
         DIV:      w_state_nxt = (r_k == c_NLAST) ? IDLE : INIT;
`endif
         default:  w_state_nxt = IDLE;
      endcase
   end

`ifdef DECONV_RESIDUAL_CHECK_EN
   logic r_mismatch;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_b        <= '0;
         r_y        <= '0;
         r_a        <= '0;
         r_acc      <= '0;
         r_k        <= '0;
         r_i        <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_inexact  <= 1'b0;
         r_ovf      <= 1'b0;
`ifdef DECONV_RESIDUAL_CHECK_EN
         r_mismatch <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_b        <= B;
                  r_y        <= Y;
                  r_a        <= '0;
                  r_k        <= '0;
                  r_inexact  <= 1'b0;
                  r_ovf      <= 1'b0;
`ifdef DECONV_RESIDUAL_CHECK_EN
                  r_mismatch <= 1'b0;
`endif
                  // A zero leading tap ends the run on the latch edge itself
                  r_div_zero <= (B[0] == '0);
                  r_done     <= (B[0] == '0);
                  r_busy     <= (B[0] != '0);
               end
            end
            INIT: begin
               r_acc <= c_AW'(w_ysel);
               r_i   <= c_IW'(1);
            end
            MAC: begin
               r_acc <= w_mac;
               r_i   <= r_i + 1'b1;
            end
            DIV: begin
               for (int j = 0; j < SIZE_N; j++)
                  if (r_k == c_IW'(j)) r_a[j] <= w_qsat;
               if (w_rem != '0) r_inexact <= 1'b1;
               if (w_sat_hi || w_sat_lo) r_ovf <= 1'b1;
               r_k <= r_k + 1'b1;
`ifndef DECONV_RESIDUAL_CHECK_EN
               if (r_k == c_NLAST) begin
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
               end
`endif
            end
`ifdef DECONV_RESIDUAL_CHECK_EN
            CHK_INIT: begin
               r_acc <= c_AW'(w_ysel);
               r_i   <= r_k - c_NLAST;
            end
            CHK_MAC: begin
               r_acc <= w_mac;
               r_i   <= r_i + 1'b1;
            end
            CHK_CMP: begin
               if (r_acc != '0) r_mismatch <= 1'b1;
               r_k <= r_k + 1'b1;
               if (r_k == c_YLAST) begin
                  r_done <= 1'b1;
                  r_busy <= 1'b0;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign A        = r_a;
   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign inexact  = r_inexact;
   assign ovf      = r_ovf;
`ifdef DECONV_RESIDUAL_CHECK_EN
   assign mismatch = r_mismatch;
`else
   assign mismatch = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_circular_deconvolution.sv
// ============================================================================
// tb_circular_deconvolution: directed vectors, scoreboard queue and done monitor.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_circular_deconvolution;

   localparam int N  = 4;
   localparam int M  = 4;
   localparam int W  = 8;
   localparam int YN = N + M - 1;
`ifdef DECONV_RESIDUAL_CHECK_EN
   localparam int LAT   = 26;
   localparam bit c_CHK = 1'b1;
`else
   localparam int LAT   = 14;
   localparam bit c_CHK = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     reset, start;
   logic [M-1:0][W-1:0]      B;
   logic [YN-1:0][2*W-1:0]   Y;
   logic [N-1:0][2*W-1:0]    A;
   logic                     busy, done, div_zero, inexact, ovf, mismatch;

   typedef struct {
      logic [N*2*W-1:0] a;
      logic             dz, inx, ov, mm;
      int               cyc;
      string            name;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   circular_deconvolution #(.SIZE_N(N), .SIZE_M(M), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .B(B), .Y(Y), .A(A),
      .busy(busy), .done(done), .div_zero(div_zero), .inexact(inexact),
      .ovf(ovf), .mismatch(mismatch)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   function automatic logic [M*W-1:0] pk_b(input int b0, b1, b2, b3);
      return {8'(b3), 8'(b2), 8'(b1), 8'(b0)};
   endfunction

   function automatic logic [N*2*W-1:0] pk_a(input int a0, a1, a2, a3);
      return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
   endfunction

   function automatic logic [YN*2*W-1:0] pk_y(input int y0, y1, y2, y3, y4, y5, y6);
      return {16'(y6), 16'(y5), 16'(y4), 16'(y3), 16'(y2), 16'(y1), 16'(y0)};
   endfunction

   // Monitor: every done pulse consumes one expected result
   exp_t m_e;
   always @(negedge clk) begin
      if (!reset && done) begin
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            m_e = sbq.pop_front();
            chk({m_e.name, "_done_cycle"}, 64'(cyc), 64'(m_e.cyc));
            chk({m_e.name, "_A"}, A, m_e.a);
            chk({m_e.name, "_div_zero"}, 64'(div_zero), 64'(m_e.dz));
            chk({m_e.name, "_inexact"}, 64'(inexact), 64'(m_e.inx));
            chk({m_e.name, "_ovf"}, 64'(ovf), 64'(m_e.ov));
            chk({m_e.name, "_mismatch"}, 64'(mismatch), 64'(m_e.mm));
         end
      end
   end

   function automatic exp_t mk(input string nm, input logic [N*2*W-1:0] a,
                               input logic dz, inx, ov, mm_on, input int c);
      exp_t e;
      e.name = nm; e.a = a; e.dz = dz; e.inx = inx; e.ov = ov;
      e.mm = mm_on & c_CHK; e.cyc = c;
      return e;
   endfunction

   task automatic run(input string nm, input logic [M*W-1:0] b, input logic [YN*2*W-1:0] y,
                      input logic [N*2*W-1:0] a, input logic dz, inx, ov, mm_on);
      @(negedge clk);
      B = b;
      Y = y;
      start = 1'b1;
      sbq.push_back(mk(nm, a, dz, inx, ov, mm_on, cyc + 1 + (dz ? 0 : LAT)));
      @(negedge clk);
      start = 1'b0;
      chk({nm, "_busy_after_start"}, 64'(busy), 64'(!dz));
   endtask

   task automatic wait_done(input string nm);
      for (int t = 0; t < 100 && sbq.size() != 0; t++) @(negedge clk);
      if (sbq.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: got %0d pending results expected 0", nm, sbq.size());
         sbq.delete();
      end
      @(negedge clk);
   endtask

   logic [M*W-1:0]     b_ex;
   logic [YN*2*W-1:0]  y_ex;
   logic [N*2*W-1:0]   a_ex;
   int                 e0;

   initial begin
      b_ex  = pk_b(1, 1, 0, 0);
      y_ex  = pk_y(1, 3, 5, 7, 4, 0, 0);
      a_ex  = pk_a(1, 2, 3, 4);
      reset = 1'b1;
      start = 1'b0;
      B     = '0;
      Y     = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_A", A, '0);
      chk("reset_status", {58'd0, busy, done, div_zero, inexact, ovf, mismatch}, '0);

      run("exact", b_ex, y_ex, a_ex, 0, 0, 0, 0);
      wait_done("exact");
      run("negative", pk_b(-1, 2, 0, 0), pk_y(-5, 13, -6, -7, 14, 0, 0),
          pk_a(5, -3, 0, 7), 0, 0, 0, 0);
      wait_done("negative");
      run("inexact", pk_b(2, 0, 0, 0), pk_y(3, 0, 0, 0, 0, 0, 0), pk_a(1, 0, 0, 0), 0, 1, 0, 0);
      wait_done("inexact");
      run("inexact_neg", pk_b(4, 0, 0, 0), pk_y(-7, 0, 0, 0, 0, 0, 0),
          pk_a(-1, 0, 0, 0), 0, 1, 0, 0);
      wait_done("inexact_neg");
      run("div_zero", pk_b(0, 1, 1, 1), pk_y(5, 5, 5, 5, 5, 5, 5), '0, 1, 0, 0, 0);
      wait_done("div_zero");
      run("saturate", pk_b(1, -128, 0, 0), pk_y(32767, 0, 0, 0, 0, 0, 0),
          pk_a(32767, 32767, 32767, 32767), 0, 0, 1, 1);
      wait_done("saturate");
      run("residual", b_ex, pk_y(1, 3, 5, 7, 4, 0, 5), a_ex, 0, 0, 0, 1);
      wait_done("residual");

      // Start pulse and input changes mid-run must not disturb the latched run
      run("busy_start", b_ex, y_ex, a_ex, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      B = pk_b(0, 0, 0, 0);
      Y = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_still_busy", 64'(busy), 64'd1);
      wait_done("busy_start");

      // Asynchronous reset at e5 of a run
      run("reset_mid", b_ex, y_ex, a_ex, 0, 0, 0, 0);
      repeat (5) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      chk("reset_mid_A", A, '0);
      chk("reset_mid_status", {58'd0, busy, done, div_zero, inexact, ovf, mismatch}, '0);
      sbq.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (LAT + 4) @(negedge clk);

      run("after_reset", b_ex, y_ex, a_ex, 0, 0, 0, 0);
      wait_done("after_reset");

      // Start held high: second run begins on the edge after the first done
      @(negedge clk);
      B = b_ex;
      Y = y_ex;
      start = 1'b1;
      e0 = cyc + 1;
      sbq.push_back(mk("held1", a_ex, 0, 0, 0, 0, e0 + LAT));
      sbq.push_back(mk("held2", a_ex, 0, 0, 0, 0, e0 + 2*LAT + 1));
      while (cyc < e0 + 2*LAT + 1) @(negedge clk);
      start = 1'b0;
      wait_done("held");
      repeat (LAT + 4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/circular_deconvolution.md
# circular_deconvolution

- Sequential inverse of the circular convolution engine: recovers input sequence A (size_n samples) from a convolution result Y (size_n+size_m-1 samples) and the known kernel B (size_m samples).
- Uses recursive polynomial division with one multiply-accumulate per cycle and one signed divide per output sample.
- Sits downstream of the convolution block, for equalisation and for self-check loopback (conv → deconv → compare A).

## Interface
- size_n, 4: length of recovered sequence A
- size_m, 4: length of kernel B
- width, 8: sample width of B; A_out and Y are 2*width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- B  in  signed width × size_m  kernel; B[0] is the leading tap
- Y  in  signed 2*width × (size_n+size_m-1)  convolution result
- A  out  signed 2*width × size_n  recovered samples, registered
- busy  out  1  high from the start edge until done
- done  out  1  one-cycle pulse when A is final
- div_zero  out  1  B[0] was 0 for this run
- inexact  out  1  sticky: any division left a nonzero remainder
- ovf  out  1  sticky: any quotient saturated
- mismatch  out  1  residual check failed (see Configuration)

## Operation
- States: IDLE, INIT, MAC, DIV, CHK_INIT, CHK_MAC, CHK_CMP.
- IDLE, start=1:
  - Latch B and Y into internal copies; later input changes do not affect the run.
  - Clear A and all flags, set k=0, busy=1.
  - If B[0]==0: set div_zero=1, pulse done, keep busy=0, stay in IDLE. A stays all zero.
- INIT: acc←Y[k], i←1.
- MAC: one term per cycle, acc←acc − B[i]*A[k−i], for i=1..min(k,size_m−1). Skipped when k=0.
- DIV:
  - q = acc / B[0], signed, truncated toward zero.
  - If the remainder is nonzero, set inexact.
  - If q lies outside the 2*width signed range, saturate it and set ovf. Later terms use the saturated value.
  - A[k]←q, k←k+1. After k=size_n−1, go to the check phase (macro on) or finish.
- Finish: done=1 and busy=0 for one cycle, return to IDLE.
- Arithmetic:
  - acc is signed, 3*width+$clog2(size_m)+1 bits.
  - Products are full-width signed B[i]×A[j].
- start while busy: ignored.
- start held high: a new run starts on the edge after the done edge.
- reset (any time, including mid-run):
  - A, busy, done, div_zero, inexact, ovf, mismatch all go to 0; state goes to IDLE.
  - The run in progress is discarded.

## Timing
- Start is sampled at edge e0.
- Output sample k costs 2+min(k,size_m−1) cycles.
- done rises at edge e0+Σ_{k=0}^{size_n−1}(2+min(k,size_m−1)) and falls one edge later.
  - Defaults, macro off: done at e14.
- A[k] is valid from its DIV edge onward and is stable after done until the next start.
- div_zero case: done at e0 (same edge as the latch).
- Check phase (macro on): for each k=size_n..size_n+size_m−2, costs 2+(size_n+size_m−1−k) cycles.
  - Defaults: +12 cycles, done at e26.

## Configuration
- Macro: DECONV_RESIDUAL_CHECK_EN.
- Defined: the CHK_* states exist. For each tail index k ≥ size_n:
  - acc←Y[k] − Σ B[i]*A[k−i] over i=k−size_n+1..size_m−1.
  - If any acc≠0, set mismatch (sticky).
  - A is unaffected.
- Undefined:
  - CHK_* states and their logic are absent; mismatch is tied to 0.
  - The run ends after the last DIV.

## Test plan
- Exact recovery: B=[1,1,0,0], Y=[1,3,5,7,4,0,0] → A=[1,2,3,4], all flags 0, done at e14 (macro off) or e26 (macro on, mismatch=0).
- Zero leading tap: B=[0,1,1,1], any Y → div_zero=1, done at e0, A all 0, busy never high.
- Inexact division: B=[2,0,0,0], Y=[3,0,0,0,0,0,0] → A=[1,0,0,0], inexact=1, ovf=0.
- Saturation: B=[1,−128,0,0], Y=[32767,0,0,0,0,0,0] → A[0]=32767, A[1]=32767 with ovf=1.
- Residual (macro on): the exact-recovery vectors with Y[6]=5 → A=[1,2,3,4], mismatch=1. Macro off: mismatch=0.
- Reset and busy handling:
  - Assert reset at e5 of a run → all outputs 0 immediately, busy 0.
  - A start pulse during busy is ignored.
  - A new start after reset repeats the exact-recovery result.
